// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display stage.
//   BCD_DIGIT_W : width of one packed BCD digit
//   state_t     : converter FSM states (encodings kept from the original header)
package bin_to_bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   digit_in  : 4-bit BCD digit before correction
//   digit_out : corrected digit
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble converter, one bit per clock, feeding the 4-digit
// seven-segment display. The result is held between conversions.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request conversion of bin (ignored while busy)
//   bin    : unsigned binary input, captured on accepted start
//   busy   : conversion in progress
//   done   : one-cycle pulse when number has just been updated
//   number : packed BCD result, MS digit in the top nibble
//   ovf    : saturation flag (present only with BIN_TO_BCD_SAT_EN)
// Build option BIN_TO_BCD_SAT_EN: saturate number to all 9s and raise ovf when
// the result needs more than DIGITS digits; otherwise the top digit is dropped.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [IN_WIDTH-1:0]           bin,
  output logic                          busy,
  output logic                          done,
`ifdef BIN_TO_BCD_SAT_EN
  output logic [BCD_DIGIT_W*DIGITS-1:0] number,
  output logic                          ovf
`else
  output logic [BCD_DIGIT_W*DIGITS-1:0] number
`endif
);

  // Scratch carries one extra digit so any 16-bit value fits before truncation.
  localparam int unsigned SW = BCD_DIGIT_W * (DIGITS + 1);
  localparam int unsigned NW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  state_t              state, state_nxt;
  logic [IN_WIDTH-1:0] shreg;
  logic [SW-1:0]       scratch;
  logic [SW-1:0]       adj;
  logic [CW-1:0]       count;

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SHIFT;
      S_SHIFT:  if (count == LAST) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      number  <= '0;
      done    <= 1'b0;
`ifdef BIN_TO_BCD_SAT_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            count   <= '0;
          end
        end
        S_SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          count            <= count + 1'b1;
        end
        S_FINISH: begin
          done <= 1'b1;
`ifdef BIN_TO_BCD_SAT_EN
          if (scratch[SW-1 -: BCD_DIGIT_W] != '0) begin
            number <= {DIGITS{4'h9}};
            ovf    <= 1'b1;
          end else begin
            number <= scratch[NW-1:0];
            ovf    <= 1'b0;
          end
`else
          number <= scratch[NW-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed-vector bench for bin_to_bcd: default 16-bit build plus an 8-bit build.
module tb_bin_to_bcd;

  logic        clk;
  logic        rst_n;
  logic        start, start8;
  logic [15:0] bin;
  logic [7:0]  bin8;
  logic        busy, busy8, done, done8;
  logic [15:0] number, number8;
  logic        ovf, ovf8;

  int checks;
  int failures;

  bin_to_bcd #(.IN_WIDTH(16), .DIGITS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
`ifdef BIN_TO_BCD_SAT_EN
    .number (number),
    .ovf    (ovf)
`else
    .number (number)
`endif
  );

  bin_to_bcd #(.IN_WIDTH(8), .DIGITS(4)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .bin    (bin8),
    .busy   (busy8),
    .done   (done8),
`ifdef BIN_TO_BCD_SAT_EN
    .number (number8),
    .ovf    (ovf8)
`else
    .number (number8)
`endif
  );

`ifndef BIN_TO_BCD_SAT_EN
  assign ovf  = 1'b0;
  assign ovf8 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts edges (sampled #1 after each) until done; lat=60 means timeout.
  // busy_bad counts cycles before done where busy was low.
  task automatic wait_done(input bit sel8, output int lat, output int busy_bad);
    lat = 0;
    busy_bad = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (sel8 ? done8 : done) break;
      if (!(sel8 ? busy8 : busy)) busy_bad++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (number !== 16'h0000) begin failures++; $display("FAIL reset_number got=%h exp=0000", number); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (number8 !== 16'h0000) begin failures++; $display("FAIL reset_number8 got=%h exp=0000", number8); end
  endtask

  task automatic test_basic();
    int lat, bb;
    @(negedge clk); bin = 16'd1234; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
    wait_done(1'b0, lat, bb);
    checks++; if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL basic_busy_low_cycles got=%0d exp=0", bb); end
    checks++; if (number !== 16'h1234) begin failures++; $display("FAIL basic_number got=%h exp=1234", number); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse_width got=%b exp=0", done); end
    checks++; if (number !== 16'h1234) begin failures++; $display("FAIL basic_number_held got=%h exp=1234", number); end
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    @(negedge clk); bin = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(1'b0, lat, bb);
    checks++; if (lat !== 17) begin failures++; $display("FAIL b2b_zero_latency got=%0d exp=17", lat); end
    checks++; if (number !== 16'h0000) begin failures++; $display("FAIL b2b_zero_number got=%h exp=0000", number); end
    bin = 16'd9999;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_in_done got=%b exp=1", busy); end
    wait_done(1'b0, lat, bb);
    checks++; if (lat !== 17) begin failures++; $display("FAIL b2b_9999_latency got=%0d exp=17", lat); end
    checks++; if (number !== 16'h9999) begin failures++; $display("FAIL b2b_9999_number got=%h exp=9999", number); end
  endtask

  task automatic test_ignore_start();
    int lat, stab, pulses, busy_hi;
    @(negedge clk); bin = 16'd1234; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0; stab = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (done) break;
      if (number !== 16'h9999) stab++;
      if (lat == 3 || lat == 10) begin start = 1'b1; bin = 16'd7; end
    end
    checks++; if (lat !== 17) begin failures++; $display("FAIL ignore_latency got=%0d exp=17", lat); end
    checks++; if (stab !== 0) begin failures++; $display("FAIL ignore_number_stable badcycles=%0d exp=0", stab); end
    checks++; if (number !== 16'h1234) begin failures++; $display("FAIL ignore_number got=%h exp=1234", number); end
    pulses = 0; busy_hi = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busy_hi++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", pulses); end
    checks++; if (busy_hi !== 0) begin failures++; $display("FAIL ignore_queued_busy got=%0d exp=0", busy_hi); end
  endtask

  task automatic test_overflow();
    int lat, bb;
    @(negedge clk); bin = 16'd65535; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(1'b0, lat, bb);
    checks++; if (lat !== 17) begin failures++; $display("FAIL ovf_latency got=%0d exp=17", lat); end
`ifdef BIN_TO_BCD_SAT_EN
    checks++; if (number !== 16'h9999) begin failures++; $display("FAIL ovf_number got=%h exp=9999", number); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`else
    checks++; if (number !== 16'h5535) begin failures++; $display("FAIL ovf_number got=%h exp=5535", number); end
`endif
    @(negedge clk); bin = 16'd42; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(1'b0, lat, bb);
    checks++; if (number !== 16'h0042) begin failures++; $display("FAIL ovf_42_number got=%h exp=0042", number); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_42_flag got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_abort();
    int lat, bb, pulses, busy_hi;
    checks++; if (number !== 16'h0042) begin failures++; $display("FAIL abort_prev_number got=%h exp=0042", number); end
    @(negedge clk); bin = 16'd1234; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (number !== 16'h0000) begin failures++; $display("FAIL abort_number got=%h exp=0000", number); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0; busy_hi = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busy_hi++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_done_after_reset got=%0d exp=0", pulses); end
    checks++; if (busy_hi !== 0) begin failures++; $display("FAIL abort_busy_after_reset got=%0d exp=0", busy_hi); end
    @(negedge clk); bin = 16'd500; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(1'b0, lat, bb);
    checks++; if (lat !== 17) begin failures++; $display("FAIL abort_500_latency got=%0d exp=17", lat); end
    checks++; if (number !== 16'h0500) begin failures++; $display("FAIL abort_500_number got=%h exp=0500", number); end
  endtask

  task automatic test_width8();
    int lat, bb;
    @(negedge clk); bin8 = 8'd255; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    wait_done(1'b1, lat, bb);
    checks++; if (lat !== 9) begin failures++; $display("FAIL w8_latency got=%0d exp=9", lat); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL w8_busy_low_cycles got=%0d exp=0", bb); end
    checks++; if (number8 !== 16'h0255) begin failures++; $display("FAIL w8_number got=%h exp=0255", number8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL w8_busy_in_done got=%b exp=0", busy8); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0; bin = '0;
    start8 = 1'b0; bin8 = '0;
    #23;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_overflow();
    test_reset_abort();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
